set_assoc_cache: RTL
====================

Name: set_assoc_cache

Overview:
- Parametrised set-associative write-back cache with write-allocate, one per processor data port.
- Sits between the core load/store port and the single-port word RAM.
- Successor to the fully-associative LRU cache: adds a configurable number of sets and ways, per-line dirty bits, and write-back of dirty victims only.
- Also adds an explicit flush sequence and hit/miss statistics counters.

Parameters:
- SETS, 4: number of sets; power of two, ≥1.
- WAYS, 2: lines per set; power of two, ≥2.
- WORDS, 4: words per line; power of two.
- DATA_WIDTH, 10: word width.
- ADDR_WIDTH, 13: word address width.
- CNT_WIDTH, 16: statistics counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  ADDR_WIDTH  word address; held stable until ready.
- read  in  1  read request level.
- write  in  1  write request level.
- write_data  in  DATA_WIDTH  store data.
- flush  in  1  flush request, sampled only in IDLE with no read or write.
- data  out  DATA_WIDTH  read data, valid when ready && read.
- ready  out  1  request complete this cycle.
- flush_done  out  1  one-cycle pulse at the end of a flush.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_read  out  1  RAM read strobe.
- ram_data_out  in  DATA_WIDTH  RAM read data, valid one cycle after ram_read.
- ram_write  out  1  RAM write strobe.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- hit_cnt  out  CNT_WIDTH  saturating count of hit completions.
- miss_cnt  out  CNT_WIDTH  saturating count of misses.

Behaviour:
- Address split:
  - offset = addr[log2 WORDS-1:0].
  - index = next log2 SETS bits.
  - tag = remaining upper bits.
- Line state: valid, dirty, tag, WORDS data words, and an LRU age of log2 WAYS bits.
- Reset, applied asynchronously at any time including mid-fill or mid-flush:
  - state IDLE, all valid and dirty bits 0, counters 0.
  - age[set][w] = WAYS-1-w, so way 0 is the first victim.
  - All outputs 0 (ram_addr, data and ram_data_in 0, not z).
- Read and write both high: treated as a read; the write is ignored.
- Hit (IDLE, tag match on a valid way of the indexed set):
  - ready is combinational in the same cycle; data = matching word.
  - Write hit: the word and dirty bit are updated at the edge.
  - The LRU update happens at the same edge.
  - hit_cnt increments once per ready cycle.
- LRU update for a way w: every way in the set with age < age[w] increments; age[w] becomes 0.
- Miss in IDLE:
  - miss_cnt increments once.
  - Victim = the way with maximum age; the lowest way index wins ties.
  - Go to WB if the victim is valid and dirty, else go to FILL.
- WB, exactly WORDS cycles, k = 0..WORDS-1:
  - ram_write=1, ram_addr = {victim tag, index, k}, ram_data_in = victim word k.
  - Then go to FILL.
- FILL, WORDS+1 cycles, k = 0..WORDS:
  - For k<WORDS: ram_read=1, ram_addr = {tag, index, k}.
  - For k≥1: word k-1 is written from ram_data_out.
  - At k=WORDS: set valid=1, dirty=0, tag; apply the LRU update for the victim way; go to IDLE.
  - The held request then hits on the next cycle and completes normally; a write sets dirty at that point.
- Flush (IDLE, flush=1, no read or write):
  - Scan set 0..SETS-1 and way 0..WAYS-1, one line per cycle for clean lines.
  - For a dirty line, perform a WB sequence identical to the miss case, then clear its dirty bit; valid and LRU are unchanged.
  - After the last line, pulse flush_done for 1 cycle and return to IDLE.
  - read, write and flush are ignored during a flush; ready=0.
- ready=0 in every state except IDLE.
- RAM strobes are 0 in IDLE.
- ram_read and ram_write are never high together.
- Counters saturate at all-ones; they do not wrap.

Test Plan:
- Defaults. After reset, read addr 0x010 → no RAM write; ram_read on 4 consecutive cycles with ram_addr 0x010..0x013; ready at cycle 6 after the request with the RAM word at 0x010; miss_cnt=1, hit_cnt=1.
- Write 0x011 ← 0x155 then read 0x011 → each returns ready in the same cycle with no RAM traffic; the read returns 0x155; hit_cnt=3.
- Fill set 0 with 0x000 and 0x010, then read 0x020 → the victim is the way holding 0x000; it is clean, so there are no ram_write cycles; then re-read 0x010 → hit.
- Dirty 0x001 (write 0x2AA), access 0x010, then 0x020 → 4 ram_write cycles at 0x000..0x003 with word 1 = 0x2AA, followed by 4 ram_read cycles at 0x020..0x023.
- Two dirty lines, then assert flush → exactly 8 ram_write cycles; flush_done pulses once; a second flush produces no ram_write.
- Assert rst during the 3rd FILL cycle → all outputs 0 immediately; the next read of the same address misses and re-fills.

Source files
------------

// File: rtl/set_assoc_cache.sv
// Set-associative write-back, write-allocate cache between a core load/store
// port and a single-port word RAM, with LRU replacement, flush and hit/miss stats.
module set_assoc_cache #(
  parameter int unsigned SETS       = 4,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned WORDS      = 4,
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  flush_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_read,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int unsigned OFF_BITS = $clog2(WORDS);
  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int unsigned TAG_W    = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int unsigned WAY_W    = $clog2(WAYS);
  localparam int unsigned K_W      = OFF_BITS + 1;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_FDONE} state_t;

  state_t                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [IDX_W-1:0]       cur_set_q, cur_set_d, fset_q, fset_d;
  logic [WAY_W-1:0]       cur_way_q, cur_way_d, fway_q, fway_d;
  logic                   flushing_q, flushing_d;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic                   valid_q [SETS][WAYS];
  logic                   valid_d [SETS][WAYS];
  logic                   dirty_q [SETS][WAYS];
  logic                   dirty_d [SETS][WAYS];
  logic [TAG_W-1:0]       tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]       tag_d   [SETS][WAYS];
  logic [WAY_W-1:0]       age_q   [SETS][WAYS];
  logic [WAY_W-1:0]       age_d   [SETS][WAYS];
  logic [DATA_WIDTH-1:0]  line_q  [SETS][WAYS][WORDS];
  logic [DATA_WIDTH-1:0]  line_d  [SETS][WAYS][WORDS];

  logic [OFF_W-1:0]       a_off;
  logic [IDX_W-1:0]       a_idx;
  logic [TAG_W-1:0]       a_tag;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way, vict_way;
  logic [WAY_W-1:0]       vmax;
  logic                   f_last;
  logic [WAY_W-1:0]       fway_nx;
  logic [IDX_W-1:0]       fset_nx;
  logic                   lru_en;
  logic [IDX_W-1:0]       lru_set;
  logic [WAY_W-1:0]       lru_way;

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Address split and per-set tag lookup / LRU victim selection
  always_comb begin
    a_off    = OFF_W'(addr & ADDR_WIDTH'(WORDS - 1));
    a_idx    = IDX_W'((addr >> OFF_BITS) & ADDR_WIDTH'(SETS - 1));
    a_tag    = TAG_W'(addr >> (OFF_BITS + IDX_BITS));
    hit      = 1'b0;
    hit_way  = '0;
    vict_way = '0;
    vmax     = age_q[a_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age_q[a_idx][w] > vmax) begin
        vmax     = age_q[a_idx][w];
        vict_way = WAY_W'(w);
      end
    end
  end

  // Flush scan position: next line and whether the current one is the last
  always_comb begin
    f_last  = (fway_q == WAY_W'(WAYS - 1)) && (fset_q == IDX_W'(SETS - 1));
    fway_nx = (fway_q == WAY_W'(WAYS - 1)) ? '0 : fway_q + WAY_W'(1);
    fset_nx = (fway_q == WAY_W'(WAYS - 1)) ? fset_q + IDX_W'(1) : fset_q;
  end

  // Next-state, line updates and outputs
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cur_set_d   = cur_set_q;
    cur_way_d   = cur_way_q;
    fset_d      = fset_q;
    fway_d      = fway_q;
    flushing_d  = flushing_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    age_d       = age_q;
    line_d      = line_q;
    data        = '0;
    ready       = 1'b0;
    flush_done  = 1'b0;
    ram_addr    = '0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_data_in = '0;
    lru_en      = 1'b0;
    lru_set     = cur_set_q;
    lru_way     = cur_way_q;

    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          if (hit) begin
            ready = 1'b1;
            if (read) begin
              data = line_q[a_idx][hit_way][a_off];
            end else begin
              line_d[a_idx][hit_way][a_off] = write_data;
              dirty_d[a_idx][hit_way]       = 1'b1;
            end
            lru_en  = 1'b1;
            lru_set = a_idx;
            lru_way = hit_way;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            cur_set_d  = a_idx;
            cur_way_d  = vict_way;
            k_d        = '0;
            flushing_d = 1'b0;
            state_d    = (valid_q[a_idx][vict_way] && dirty_q[a_idx][vict_way]) ? S_WB : S_FILL;
          end
        end else if (flush) begin
          fset_d  = '0;
          fway_d  = '0;
          state_d = S_FLUSH;
        end
      end
      S_WB: begin
        ram_write   = 1'b1;
        ram_addr    = (ADDR_WIDTH'(tag_q[cur_set_q][cur_way_q]) << (OFF_BITS + IDX_BITS))
                    | (ADDR_WIDTH'(cur_set_q) << OFF_BITS) | ADDR_WIDTH'(OFF_W'(k_q));
        ram_data_in = line_q[cur_set_q][cur_way_q][OFF_W'(k_q)];
        if (k_q == K_W'(WORDS - 1)) begin
          k_d = '0;
          if (flushing_q) begin
            dirty_d[cur_set_q][cur_way_q] = 1'b0;
            if (f_last) begin
              state_d = S_FDONE;
            end else begin
              fset_d  = fset_nx;
              fway_d  = fway_nx;
              state_d = S_FLUSH;
            end
          end else begin
            state_d = S_FILL;
          end
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_FILL: begin
        if (k_q != K_W'(WORDS)) begin
          ram_read = 1'b1;
          ram_addr = (ADDR_WIDTH'(a_tag) << (OFF_BITS + IDX_BITS))
                   | (ADDR_WIDTH'(cur_set_q) << OFF_BITS) | ADDR_WIDTH'(OFF_W'(k_q));
        end
        if (k_q != '0) line_d[cur_set_q][cur_way_q][OFF_W'(k_q - K_W'(1))] = ram_data_out;
        if (k_q == K_W'(WORDS)) begin
          valid_d[cur_set_q][cur_way_q] = 1'b1;
          dirty_d[cur_set_q][cur_way_q] = 1'b0;
          tag_d[cur_set_q][cur_way_q]   = a_tag;
          lru_en  = 1'b1;
          k_d     = '0;
          state_d = S_IDLE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_FLUSH: begin
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          cur_set_d  = fset_q;
          cur_way_d  = fway_q;
          flushing_d = 1'b1;
          k_d        = '0;
          state_d    = S_WB;
        end else if (f_last) begin
          state_d = S_FDONE;
        end else begin
          fset_d = fset_nx;
          fway_d = fway_nx;
        end
      end
      S_FDONE: begin
        flush_done = 1'b1;
        flushing_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // LRU touch: younger ways age by one, the touched way becomes youngest
    if (lru_en) begin
      for (int v = 0; v < WAYS; v++) begin
        if (age_q[lru_set][v] < age_q[lru_set][lru_way]) age_d[lru_set][v] = age_q[lru_set][v] + WAY_W'(1);
      end
      age_d[lru_set][lru_way] = '0;
    end
  end

  // State and line storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      cur_set_q  <= '0;
      cur_way_q  <= '0;
      fset_q     <= '0;
      fway_q     <= '0;
      flushing_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '{default: 1'b0};
      dirty_q    <= '{default: 1'b0};
      tag_q      <= '{default: '0};
      line_q     <= '{default: '0};
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(WAYS - 1 - w);
        end
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cur_set_q  <= cur_set_d;
      cur_way_q  <= cur_way_d;
      fset_q     <= fset_d;
      fway_q     <= fway_d;
      flushing_q <= flushing_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      age_q      <= age_d;
      line_q     <= line_d;
    end
  end

endmodule
